// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

    // Default number of data bits per frame, shared with the receive side
    localparam int UART_DATA_W = 8;

    // Parity sense selector values
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Transmit sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP1  = 3'd5,
        STOP2  = 3'd6
    } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame sequencer driven by the baud tick
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              two_stop,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    uart_tx_state_e    state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pen_q, pen_d;
    logic              two_q, two_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;

    assign tx_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign tx         = tx_q;
    assign frame_done = done_q;

    // State, datapath and registered line outputs; reset aborts any frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            pen_q   <= 1'b0;
            two_q   <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            pen_q   <= pen_d;
            two_q   <= two_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Next-state, shift/count update and next line level
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        pen_d   = pen_q;
        two_d   = two_q;
        par_d   = par_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;

        case (state_q)
            IDLE: begin
                // A tick in the accept cycle is deliberately ignored: SYNC waits for the next one
                if (tx_valid) begin
                    state_d = SYNC;
                    shift_d = tx_data;
                    cnt_d   = '0;
                    pen_d   = parity_en;
                    two_d   = two_stop;
                    par_d   = (^tx_data) ^ (parity_odd == PARITY_ODD);
                end
            end
            SYNC: begin
                if (baud_tick) begin
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = pen_q ? PARITY : STOP1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP1;
                end
            end
            STOP1: begin
                if (baud_tick) begin
                    if (two_q) begin
                        state_d = STOP2;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (baud_tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The line level follows the state being entered so tx moves on the tick edge
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - randomized self-checking bench for uart_tx_ctrl
module tb_uart_tx_ctrl;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          baud_tick;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          parity_en;
    logic          parity_odd;
    logic          two_stop;
    logic          tx;
    logic          busy;
    logic          frame_done;

    int n_vec  = 0;
    int n_err  = 0;
    int period = 4;
    int tcnt   = 0;
    bit last_tick;

    uart_tx_ctrl #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_tick  (baud_tick),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: report whether the edge sampled a tick, then advance the free-running tick
    task automatic cycle();
        @(posedge clk);
        last_tick = baud_tick;
        #1;
        tcnt      = (tcnt + 1) % period;
        baud_tick = (tcnt == 0);
    endtask

    // Present one word and follow the whole frame against the expected bit list.
    // abort_at > 0 pulls reset once that many ticks of the frame have elapsed.
    task automatic run_frame(input logic [DW-1:0] data, input bit pen, input bit podd,
                             input bit two, input bit keep_valid, input bit mid_change,
                             input int abort_at);
        bit q[$];
        int seen;
        int guard;
        q.push_back(1'b0);
        for (int i = 0; i < DW; i++) q.push_back(data[i]);
        if (pen) q.push_back((^data) ^ podd);
        q.push_back(1'b1);
        if (two) q.push_back(1'b1);

        tx_data    = data;
        parity_en  = pen;
        parity_odd = podd;
        two_stop   = two;
        tx_valid   = 1'b1;
        guard      = 0;
        while (!tx_ready && guard < 500) begin
            cycle();
            guard++;
        end
        chk("accept_wait", {31'd0, tx_ready}, 32'd1);
        cycle();
        if (!keep_valid) tx_valid = 1'b0;

        seen  = 0;
        guard = 0;
        while (seen <= q.size() && guard < 2000) begin
            cycle();
            guard++;
            if (last_tick) seen++;
            if (seen <= q.size()) begin
                chk("tx",    {31'd0, tx}, (seen == 0) ? 32'd1 : {31'd0, q[seen-1]});
                chk("busy",  {31'd0, busy}, 32'd1);
                chk("ready", {31'd0, tx_ready}, 32'd0);
                chk("done",  {31'd0, frame_done}, 32'd0);
            end else begin
                chk("tx_end",    {31'd0, tx}, 32'd1);
                chk("busy_end",  {31'd0, busy}, 32'd0);
                chk("ready_end", {31'd0, tx_ready}, 32'd1);
                chk("done_end",  {31'd0, frame_done}, 32'd1);
            end
            if (mid_change && seen == 3) begin
                parity_en = ~pen;
                two_stop  = ~two;
                tx_data   = ~data;
                tx_valid  = 1'b1;
            end
            if (mid_change && seen == q.size()) tx_valid = 1'b0;
            if (abort_at > 0 && seen == abort_at) begin
                #2 rst = 1'b0;
                #1;
                chk("abort_tx",    {31'd0, tx}, 32'd1);
                chk("abort_busy",  {31'd0, busy}, 32'd0);
                chk("abort_ready", {31'd0, tx_ready}, 32'd1);
                chk("abort_done",  {31'd0, frame_done}, 32'd0);
                tx_valid = 1'b0;
                return;
            end
        end
        if (guard >= 2000) chk("frame_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst        = 1'b0;
        baud_tick  = 1'b0;
        tx_data    = '0;
        tx_valid   = 1'b0;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        two_stop   = 1'b0;
        period     = 4;

        repeat (3) cycle();
        chk("rst_tx",    {31'd0, tx}, 32'd1);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_done",  {31'd0, frame_done}, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            chk("idle_tx",   {31'd0, tx}, 32'd1);
            chk("idle_busy", {31'd0, busy}, 32'd0);
        end

        // Basic, parity even/odd, parity bit set by data
        run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Two stop bits with the next word already waiting
        run_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        run_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Config and data changes mid-frame are ignored
        run_frame(8'h96, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        run_frame(8'h4B, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);

        // Ticks on every clock
        period = 1;
        run_frame(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        period = 4;

        // Reset during data bit 3, then a clean frame
        run_frame(8'hE1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5);
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        chk("post_rst_tx", {31'd0, tx}, 32'd1);
        run_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Randomized frames, tick spacing and back-to-back presentation
        for (int n = 0; n < 40; n++) begin
            period = $urandom_range(1, 5);
            run_frame(DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom_range(0, 3) == 0), 0);
        end
        tx_valid = 1'b0;
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
